// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer:
// FSM state encoding and the width of the adder slice.
package nibble_serial_addsub_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_cla.sv
// 4-bit carry-lookahead adder slice; all carries are formed in parallel
// from generate/propagate terms rather than rippled.
module sumadorCarryLook_4bits (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Adds or subtracts WIDTH-bit operands one nibble per clock through a single
// shared 4-bit CLA slice, threading the carry between nibbles in a flop.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
            $error("nibble_serial_addsub_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_opA;
    logic [WIDTH-1:0]    r_opB;
    logic [WIDTH-1:0]    r_res;
    logic                r_carry;
    logic                r_co;
    logic                r_ovf;
    logic                r_amsb;
    logic                r_bmsb;
    logic                r_done;

    logic [NIBBLE_W-1:0] w_sum;
    logic                w_cout;
    logic                w_ready;
    logic                w_accept;
    logic                w_run;
    logic                w_last;
    logic [WIDTH+3:0]    w_res_next;

    sumadorCarryLook_4bits u_cla (
        .i_a    (r_opA[NIBBLE_W-1:0]),
        .i_b    (r_opB[NIBBLE_W-1:0]),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept   = start && w_ready;
    assign w_run      = (r_state == ST_RUN);
    assign w_last     = w_run && (r_cnt == CNT_W'(NIB - 1));
    // New sum nibble enters at the MSB end; after NIB shifts the LSB nibble sits at the bottom.
    assign w_res_next = {w_sum, r_res};

    // Operand shifters carry no control meaning, so they are left unreset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opA <= A;
            r_opB <= op_sub ? ~B : B;
        end else if (w_run) begin
            r_opA <= r_opA >> NIBBLE_W;
            r_opB <= r_opB >> NIBBLE_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // Subtract is A + ~B + 1: the +1 rides in as the first carry-in.
                r_carry <= op_sub;
                r_res   <= '0;
                r_cnt   <= '0;
                r_amsb  <= A[WIDTH-1];
                r_bmsb  <= op_sub ? ~B[WIDTH-1] : B[WIDTH-1];
                r_state <= ST_RUN;
            end else if (w_run) begin
                r_res   <= w_res_next[WIDTH+3:NIBBLE_W];
                r_carry <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_co    <= w_cout;
                    r_ovf   <= (r_amsb == r_bmsb) && (w_sum[NIBBLE_W-1] != r_amsb);
                end
            end
        end
    end

    assign ready = w_ready;
    assign done  = r_done;
    assign S     = r_res;
    assign Co    = r_co;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for nibble_serial_addsub_ctrl (WIDTH=16 and WIDTH=4) with a
// queue of expected results scored whenever done pulses.
module tb_nibble_serial_addsub_ctrl;

    localparam int NIB16 = 4;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start, op_sub;
    logic [15:0] A, B;
    logic        ready, done, Co, ovf;
    logic [15:0] S;

    logic        start4, op_sub4;
    logic [3:0]  A4, B4;
    logic        ready4, done4, Co4, ovf4;
    logic [3:0]  S4;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [15:0] last_s;

    nibble_serial_addsub_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .A(A), .B(B),
        .ready(ready), .done(done), .S(S), .Co(Co), .ovf(ovf)
    );

    nibble_serial_addsub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op_sub(op_sub4), .A(A4), .B(B4),
        .ready(ready4), .done(done4), .S(S4), .Co(Co4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, independent of the nibble datapath.
    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic sub);
        exp_t        e;
        logic [16:0] t;
        int          ra, rb, r;
        ra = int'($signed(a));
        rb = int'($signed(b));
        r  = sub ? (ra - rb) : (ra + rb);
        t  = {1'b0, a} + {1'b0, b};
        e.s   = sub ? (a - b) : (a + b);
        e.co  = sub ? (a >= b) : t[16];
        e.ovf = (r > 32767) || (r < -32768);
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                            input bit expect_result);
        A = a; B = b; op_sub = sub; start = 1'b1;
        if (expect_result) push_exp(a, b, sub);
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); op_sub = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input int lat);
        int   n;
        bit   seen;
        exp_t e;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_latency"}, 32'(n), 32'(lat));
            chk({tag, "_ready"}, 32'(ready), 32'd1);
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_S"}, 32'(S), 32'(e.s));
                chk({tag, "_Co"}, 32'(Co), 32'(e.co));
                chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
                last_s = e.s;
            end
        end
    endtask

    task automatic check_hold(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_S_held"}, 32'(S), 32'(last_s));
        chk({tag, "_ready_held"}, 32'(ready), 32'd1);
    endtask

    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic sub, input logic [3:0] es, input logic eco,
                        input logic eovf);
        int n;
        bit seen;
        A4 = a; B4 = b; op_sub4 = sub; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (done4 === 1'b1) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd1);
        chk({tag, "_S"}, 32'(S4), 32'(es));
        chk({tag, "_Co"}, 32'(Co4), 32'(eco));
        chk({tag, "_ovf"}, 32'(ovf4), 32'(eovf));
    endtask

    initial begin
        int spurious;
        rst_n = 1'b0;
        start = 1'b0; op_sub = 1'b0; A = '0; B = '0;
        start4 = 1'b0; op_sub4 = 1'b0; A4 = '0; B4 = '0;
        last_s = '0;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_Co", 32'(Co), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst4_ready", 32'(ready4), 32'd1);
        chk("rst4_S", 32'(S4), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_op(16'h1234, 16'h0FCD, 1'b0, 1'b1);
        wait_done("add_basic", NIB16);
        check_hold("add_basic");
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_done("add_wrap", NIB16);
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_done("add_ovf", NIB16);
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done("sub_borrow", NIB16);
        start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_done("sub_ovf", NIB16);
        check_hold("sub_ovf");

        // start during RUN must be ignored
        start_op(16'h1111, 16'h2222, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("run_ready_low", 32'(ready), 32'd0);
        start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; op_sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_in_run", NIB16 - 2);

        // start in the done cycle is accepted
        start_op(16'hABCD, 16'h1234, 1'b1, 1'b1);
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_ready_low", 32'(ready), 32'd0);
        wait_done("back_to_back", NIB16);

        // reset during the third RUN cycle aborts the operation
        start_op(16'h4321, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_S", 32'(S), 32'd0);
        chk("abort_Co", 32'(Co), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < NIB16 + 3; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) spurious++;
        end
        chk("abort_no_done", 32'(spurious), 32'd0);
        chk("abort_idle_ready", 32'(ready), 32'd1);
        start_op(16'h00FF, 16'h0F01, 1'b1, 1'b1);
        wait_done("after_abort", NIB16);
        start_op(16'h8000, 16'h8000, 1'b0, 1'b1);
        wait_done("add_neg_ovf", NIB16);

        run4("w4_add", 4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1);
        run4("w4_sub", 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
